// File: rtl/gcl_cmd_sched.sv
// Blocking sequencer from the gcl op stream onto memory ports A and B.
// Handles one op at a time: write, read, copy (read then write), or an illegal-op error response.
module gcl_cmd_sched #(
  parameter int unsigned A_SIZE  = 18,
  parameter int unsigned DQ_SIZE = 9,
  parameter int unsigned RD_LAT  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [31:0]          cmd_id,
  input  logic [2:0]           cmd,
  input  logic [A_SIZE-1:0]    cmd_adr1,
  input  logic [A_SIZE-1:0]    cmd_adr2,
  input  logic [4*DQ_SIZE-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_id,
  output logic [2:0]           rsp_cmd,
  output logic [4*DQ_SIZE-1:0] rsp_data,
  output logic                 rsp_err,
  output logic                 a_rd,
  output logic                 a_wr,
  output logic [A_SIZE-1:0]    a_adr,
  output logic [4*DQ_SIZE-1:0] a_wdata,
  input  logic [4*DQ_SIZE-1:0] a_rdata,
  output logic                 b_rd,
  output logic                 b_wr,
  output logic [A_SIZE-1:0]    b_adr,
  output logic [4*DQ_SIZE-1:0] b_wdata,
  input  logic [4*DQ_SIZE-1:0] b_rdata
);

  localparam int unsigned D_W   = 4 * DQ_SIZE;
  localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_RDA  = 3'd1;
  localparam logic [2:0] CMD_RDB  = 3'd2;
  localparam logic [2:0] CMD_WRA  = 3'd3;
  localparam logic [2:0] CMD_WRB  = 3'd4;
  localparam logic [2:0] CMD_CPAB = 3'd5;
  localparam logic [2:0] CMD_CPBA = 3'd6;
  localparam logic [2:0] CMD_ILL  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_ISSUE, S_WAIT, S_RESP, S_CPWR
  } state_t;

  typedef struct packed {
    logic [31:0]       id;
    logic [2:0]        cmd;
    logic [A_SIZE-1:0] adr1;
    logic [A_SIZE-1:0] adr2;
    logic [D_W-1:0]    wdata;
  } op_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  op_t                op, op_d;
  logic [D_W-1:0]     cp_data;

  logic               cmd_ready_d, rsp_valid_d, rsp_err_d;
  logic [31:0]        rsp_id_d;
  logic [2:0]         rsp_cmd_d;
  logic [D_W-1:0]     rsp_data_d;
  logic               a_rd_d, a_wr_d, b_rd_d, b_wr_d;
  logic [A_SIZE-1:0]  a_adr_d, b_adr_d;
  logic [D_W-1:0]     a_wdata_d, b_wdata_d;

  // Next state plus next-cycle outputs, decoded from the state being entered.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    op_d        = op;
    cp_data     = '0;
    cmd_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = '0;
    rsp_cmd_d   = '0;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;
    a_rd_d      = 1'b0;
    a_wr_d      = 1'b0;
    a_adr_d     = '0;
    a_wdata_d   = '0;
    b_rd_d      = 1'b0;
    b_wr_d      = 1'b0;
    b_adr_d     = '0;
    b_wdata_d   = '0;

    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d = {cmd_id, cmd, cmd_adr1, cmd_adr2, cmd_wdata};
          case (cmd)
            CMD_WRA, CMD_WRB: state_d = S_WR;
            CMD_NOP, CMD_RDA, CMD_RDB, CMD_CPAB, CMD_CPBA: state_d = S_ISSUE;
            default: state_d = S_RESP;
          endcase
        end
      end
      S_WR:    state_d = S_IDLE;
      S_ISSUE: begin
        cnt_d   = CNT_W'(RD_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_d = (op.cmd == CMD_CPAB || op.cmd == CMD_CPBA) ? S_CPWR : S_RESP;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_CPWR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);

    case (state_d)
      S_WR: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = op_d.id;
        rsp_cmd_d   = op_d.cmd;
        rsp_data_d  = op_d.wdata;
        if (op_d.cmd == CMD_WRA) begin
          a_wr_d    = 1'b1;
          a_adr_d   = op_d.adr1;
          a_wdata_d = op_d.wdata;
        end else begin
          b_wr_d    = 1'b1;
          b_adr_d   = op_d.adr1;
          b_wdata_d = op_d.wdata;
        end
      end
      S_ISSUE: begin
        case (op_d.cmd)
          CMD_NOP: begin
            a_rd_d = 1'b1;
            b_rd_d = 1'b1;
          end
          CMD_RDA, CMD_CPAB: begin
            a_rd_d  = 1'b1;
            a_adr_d = op_d.adr1;
          end
          default: begin
            b_rd_d  = 1'b1;
            b_adr_d = op_d.adr1;
          end
        endcase
      end
      // Read data is valid on the port during the last WAIT cycle and is registered here.
      S_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = op_d.id;
        rsp_cmd_d   = op_d.cmd;
        rsp_err_d   = (op_d.cmd == CMD_ILL);
        if (op_d.cmd == CMD_RDA) begin
          rsp_data_d = a_rdata;
        end else if (op_d.cmd == CMD_RDB) begin
          rsp_data_d = b_rdata;
        end
      end
      S_CPWR: begin
        cp_data     = (op_d.cmd == CMD_CPAB) ? a_rdata : b_rdata;
        rsp_valid_d = 1'b1;
        rsp_id_d    = op_d.id;
        rsp_cmd_d   = op_d.cmd;
        rsp_data_d  = cp_data;
        if (op_d.cmd == CMD_CPAB) begin
          b_wr_d    = 1'b1;
          b_adr_d   = op_d.adr2;
          b_wdata_d = cp_data;
        end else begin
          a_wr_d    = 1'b1;
          a_adr_d   = op_d.adr2;
          a_wdata_d = cp_data;
        end
      end
      default: ;
    endcase
  end

  // State and registered outputs; reset drops any op in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op        <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_cmd   <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      a_rd      <= 1'b0;
      a_wr      <= 1'b0;
      a_adr     <= '0;
      a_wdata   <= '0;
      b_rd      <= 1'b0;
      b_wr      <= 1'b0;
      b_adr     <= '0;
      b_wdata   <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      op        <= op_d;
      cmd_ready <= cmd_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_id    <= rsp_id_d;
      rsp_cmd   <= rsp_cmd_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
      a_rd      <= a_rd_d;
      a_wr      <= a_wr_d;
      a_adr     <= a_adr_d;
      a_wdata   <= a_wdata_d;
      b_rd      <= b_rd_d;
      b_wr      <= b_wr_d;
      b_adr     <= b_adr_d;
      b_wdata   <= b_wdata_d;
    end
  end

endmodule

// File: tb/tb_gcl_cmd_sched.sv
// Bench for gcl_cmd_sched: directed and random ops against a per-op timeline model
// with its own reference memories, plus a latency-accurate two-port memory.
module tb_gcl_cmd_sched;

  localparam int unsigned A_SIZE  = 18;
  localparam int unsigned DQ_SIZE = 9;
  localparam int unsigned RD_LAT  = 3;
  localparam int unsigned D_W     = 4 * DQ_SIZE;

  localparam bit [2:0] NOP = 3'd0, RDA = 3'd1, RDB = 3'd2, WRA = 3'd3,
                       WRB = 3'd4, CPAB = 3'd5, CPBA = 3'd6, ILL = 3'd7;

  logic              clk, rst_n;
  logic              cmd_valid, cmd_ready;
  logic [31:0]       cmd_id;
  logic [2:0]        cmd;
  logic [A_SIZE-1:0] cmd_adr1, cmd_adr2;
  logic [D_W-1:0]    cmd_wdata;
  logic              rsp_valid, rsp_err;
  logic [31:0]       rsp_id;
  logic [2:0]        rsp_cmd;
  logic [D_W-1:0]    rsp_data;
  logic              a_rd, a_wr, b_rd, b_wr;
  logic [A_SIZE-1:0] a_adr, b_adr;
  logic [D_W-1:0]    a_wdata, b_wdata, a_rdata, b_rdata;

  gcl_cmd_sched #(.A_SIZE(A_SIZE), .DQ_SIZE(DQ_SIZE), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd(cmd),
    .cmd_adr1(cmd_adr1), .cmd_adr2(cmd_adr2), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_cmd(rsp_cmd),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .a_rd(a_rd), .a_wr(a_wr), .a_adr(a_adr), .a_wdata(a_wdata), .a_rdata(a_rdata),
    .b_rd(b_rd), .b_wr(b_wr), .b_adr(b_adr), .b_wdata(b_wdata), .b_rdata(b_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Port memories (driven by DUT strobes) and reference memories (driven by the op model)
  bit [D_W-1:0] pmem_a [bit [A_SIZE-1:0]];
  bit [D_W-1:0] pmem_b [bit [A_SIZE-1:0]];
  bit [D_W-1:0] ref_a  [bit [A_SIZE-1:0]];
  bit [D_W-1:0] ref_b  [bit [A_SIZE-1:0]];
  logic [D_W-1:0] pipe_a [RD_LAT];
  logic [D_W-1:0] pipe_b [RD_LAT];

  function automatic bit [D_W-1:0] fillv(input bit pb, input bit [A_SIZE-1:0] adr);
    return {adr, ~adr} ^ (pb ? 36'h5A5A5A5A5 : 36'h0);
  endfunction

  function automatic bit [D_W-1:0] port_rd(input bit pb, input bit [A_SIZE-1:0] adr);
    if (pb) return pmem_b.exists(adr) ? pmem_b[adr] : fillv(1'b1, adr);
    return pmem_a.exists(adr) ? pmem_a[adr] : fillv(1'b0, adr);
  endfunction

  function automatic bit [D_W-1:0] ref_rd(input bit pb, input bit [A_SIZE-1:0] adr);
    if (pb) return ref_b.exists(adr) ? ref_b[adr] : fillv(1'b1, adr);
    return ref_a.exists(adr) ? ref_a[adr] : fillv(1'b0, adr);
  endfunction

  // Read data appears RD_LAT cycles after the strobe cycle; other cycles carry noise.
  always @(posedge clk) begin
    bit [D_W-1:0] ra, rb;
    ra = a_rd ? port_rd(1'b0, a_adr) : D_W'({$urandom(), $urandom()});
    rb = b_rd ? port_rd(1'b1, b_adr) : D_W'({$urandom(), $urandom()});
    for (int i = RD_LAT - 1; i > 0; i--) begin
      pipe_a[i] <= pipe_a[i-1];
      pipe_b[i] <= pipe_b[i-1];
    end
    pipe_a[0] <= ra;
    pipe_b[0] <= rb;
    if (a_wr) pmem_a[a_adr] = a_wdata;
    if (b_wr) pmem_b[b_adr] = b_wdata;
  end
  assign a_rdata = pipe_a[RD_LAT-1];
  assign b_rdata = pipe_b[RD_LAT-1];

  typedef struct packed {
    bit rdy; bit rv; bit [31:0] rid; bit [2:0] rcmd; bit [D_W-1:0] rdat; bit rerr;
    bit ard; bit awr; bit [A_SIZE-1:0] aadr; bit [D_W-1:0] awd;
    bit brd; bit bwr; bit [A_SIZE-1:0] badr; bit [D_W-1:0] bwd;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input exp_t e, input string ctx);
    chk({ctx, " cmd_ready"}, 64'(cmd_ready), 64'(e.rdy));
    chk({ctx, " rsp_valid"}, 64'(rsp_valid), 64'(e.rv));
    chk({ctx, " rsp_id"},    64'(rsp_id),    64'(e.rid));
    chk({ctx, " rsp_cmd"},   64'(rsp_cmd),   64'(e.rcmd));
    chk({ctx, " rsp_data"},  64'(rsp_data),  64'(e.rdat));
    chk({ctx, " rsp_err"},   64'(rsp_err),   64'(e.rerr));
    chk({ctx, " a_rd"},      64'(a_rd),      64'(e.ard));
    chk({ctx, " a_wr"},      64'(a_wr),      64'(e.awr));
    chk({ctx, " a_adr"},     64'(a_adr),     64'(e.aadr));
    chk({ctx, " a_wdata"},   64'(a_wdata),   64'(e.awd));
    chk({ctx, " b_rd"},      64'(b_rd),      64'(e.brd));
    chk({ctx, " b_wr"},      64'(b_wr),      64'(e.bwr));
    chk({ctx, " b_adr"},     64'(b_adr),     64'(e.badr));
    chk({ctx, " b_wdata"},   64'(b_wdata),   64'(e.bwd));
  endtask

  task automatic scramble_cmd(input bit allow_valid);
    cmd_valid = allow_valid ? 1'($urandom_range(0, 1)) : 1'b0;
    cmd_id    = $urandom();
    cmd       = 3'($urandom());
    cmd_adr1  = A_SIZE'($urandom());
    cmd_adr2  = A_SIZE'($urandom());
    cmd_wdata = D_W'({$urandom(), $urandom()});
  endtask

  // Called at the negedge of an idle cycle; each cycle is checked at its negedge.
  task automatic idle_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = '0;
      e.rdy = 1'b1;
      check_outs(e, "idle");
      scramble_cmd(1'b0);
      @(negedge clk);
    end
  endtask

  // One op offered in an idle cycle T; expects the whole T+1..T+lat timeline, ends at T+lat+1.
  task automatic do_op(input bit [31:0] id, input bit [2:0] c, input bit [A_SIZE-1:0] a1,
                       input bit [A_SIZE-1:0] a2, input bit [D_W-1:0] wd);
    exp_t e;
    int lat;
    bit [D_W-1:0] v;
    e = '0;
    e.rdy = 1'b1;
    check_outs(e, "accept");
    cmd_valid = 1'b1; cmd_id = id; cmd = c; cmd_adr1 = a1; cmd_adr2 = a2; cmd_wdata = wd;
    lat = (c == WRA || c == WRB || c == ILL) ? 1 : 2 + int'(RD_LAT);
    v = '0;
    case (c)
      RDA:  v = ref_rd(1'b0, a1);
      RDB:  v = ref_rd(1'b1, a1);
      WRA:  ref_a[a1] = wd;
      WRB:  ref_b[a1] = wd;
      CPAB: begin v = ref_rd(1'b0, a1); ref_b[a2] = v; end
      CPBA: begin v = ref_rd(1'b1, a1); ref_a[a2] = v; end
      default: ;
    endcase
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      e = '0;
      if (k == 1) begin
        case (c)
          NOP:  begin e.ard = 1'b1; e.brd = 1'b1; end
          RDA, CPAB: begin e.ard = 1'b1; e.aadr = a1; end
          RDB, CPBA: begin e.brd = 1'b1; e.badr = a1; end
          WRA:  begin e.awr = 1'b1; e.aadr = a1; e.awd = wd; end
          WRB:  begin e.bwr = 1'b1; e.badr = a1; e.bwd = wd; end
          default: ;
        endcase
      end
      if (k == lat) begin
        e.rv   = 1'b1;
        e.rid  = id;
        e.rcmd = c;
        e.rerr = (c == ILL);
        e.rdat = (c == WRA || c == WRB) ? wd : (c == NOP || c == ILL) ? '0 : v;
        if (c == CPAB) begin e.bwr = 1'b1; e.badr = a2; e.bwd = v; end
        if (c == CPBA) begin e.awr = 1'b1; e.aadr = a2; e.awd = v; end
      end
      check_outs(e, $sformatf("id%0h cmd%0d cyc%0d", id, c, k));
      scramble_cmd(1'b1);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bit [2:0] c;
    bit [A_SIZE-1:0] a1, a2;
    for (int i = 0; i < int'(RD_LAT); i++) begin
      pipe_a[i] = '0;
      pipe_b[i] = '0;
    end
    pmem_b[18'h3FFFF] = 36'hFEDCBA987;
    ref_b[18'h3FFFF]  = 36'hFEDCBA987;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_id = '0; cmd = '0; cmd_adr1 = '0; cmd_adr2 = '0; cmd_wdata = '0;

    // Reset held for three cycles: everything low, then ready one cycle after release
    repeat (3) @(negedge clk);
    e = '0;
    check_outs(e, "in_reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_op(32'd1, WRA, 18'h00010, 18'h0, 36'h123456789);
    do_op(32'd2, RDB, 18'h3FFFF, 18'h0, 36'h0);
    do_op(32'd3, CPAB, 18'h00010, 18'h00020, 36'h0);
    do_op(32'd4, RDB, 18'h00020, 18'h0, 36'h0);
    do_op(32'd5, ILL, 18'h00011, 18'h00022, 36'h111111111);
    do_op(32'd6, NOP, 18'h00033, 18'h00044, 36'h222222222);
    do_op(32'd7, WRB, 18'h00005, 18'h0, 36'hABCDEF012);
    do_op(32'd8, CPBA, 18'h00005, 18'h00005, 36'h0);
    do_op(32'd9, CPAB, 18'h00005, 18'h00005, 36'h0);
    do_op(32'd10, RDA, 18'h00005, 18'h0, 36'h0);

    // Reset during the WAIT of an RDA: no response for it, next op behaves normally
    cmd_valid = 1'b1; cmd_id = 32'hDEAD; cmd = RDA; cmd_adr1 = 18'h00010;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    e = '0;
    check_outs(e, "mid_reset");
    rst_n = 1'b1;
    @(negedge clk);
    idle_cycles(int'(RD_LAT) + 3);
    do_op(32'd11, RDA, 18'h00010, 18'h0, 36'h0);

    for (int n = 0; n < 150; n++) begin
      c  = 3'($urandom());
      a1 = ($urandom_range(0, 9) == 0) ? A_SIZE'($urandom()) : A_SIZE'($urandom_range(0, 7));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : A_SIZE'($urandom_range(0, 7));
      idle_cycles($urandom_range(0, 2));
      do_op(32'h1000 + 32'(n), c, a1, a2, D_W'({$urandom(), $urandom()}));
    end
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
